// File: rtl/dbf_pkg.sv
// Shared DBF types, constants and the product round/saturate helper.
// DBF_ROUND_EN selects round-half-up; otherwise the product is floored.
package dbf_pkg;

  localparam int unsigned DBF_DW     = 16;
  localparam int unsigned DBF_NUM_CH = 16;
  localparam int unsigned DBF_PW     = 2 * DBF_DW;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [DBF_DW-1:0] amp;
    logic signed [DBF_DW-1:0] re;
    logic signed [DBF_DW-1:0] im;
  } weight_t;

  localparam logic signed [DBF_DW-1:0] SAT_MAX = {1'b0, {(DBF_DW-1){1'b1}}};
  localparam logic signed [DBF_DW-1:0] SAT_MIN = {1'b1, {(DBF_DW-1){1'b0}}};

  // Q1 x Q2 product back to Q2: shift by DW-1, then clamp to the output range.
  function automatic logic signed [DBF_DW-1:0] sat_shift(input logic signed [DBF_PW-1:0] p);
    logic signed [DBF_PW:0] acc;
    acc = {p[DBF_PW-1], p};
`ifdef DBF_ROUND_EN
    acc = acc + (DBF_PW+1)'(2 ** (DBF_DW - 2));
`endif
    acc = acc >>> (DBF_DW - 1);
    if (acc > (DBF_PW+1)'(SAT_MAX)) return SAT_MAX;
    if (acc < (DBF_PW+1)'(SAT_MIN)) return SAT_MIN;
    return acc[DBF_DW-1:0];
  endfunction

endpackage

// File: rtl/dbf_weight_seq_if.sv
// Table-write, control and weight-stream signals of dbf_weight_seq.
// master = weight generator side, slave = host / beamformer side.
interface dbf_weight_seq_if
  import dbf_pkg::*;
#(
  parameter int unsigned NUM_CH = DBF_NUM_CH,
  parameter int unsigned DW     = DBF_DW
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            wr_en;
  logic [CH_W-1:0] wr_addr;
  logic [DW-1:0]   wr_amp;
  logic [DW-1:0]   wr_re;
  logic [DW-1:0]   wr_im;
  logic            wr_err;
  logic            start;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic            out_last;
  logic [DW-1:0]   out_re;
  logic [DW-1:0]   out_im;

  modport master (
    input  wr_en, wr_addr, wr_amp, wr_re, wr_im, start, out_ready,
    output wr_err, busy, out_valid, out_ch, out_last, out_re, out_im
  );

  modport slave (
    output wr_en, wr_addr, wr_amp, wr_re, wr_im, start, out_ready,
    input  wr_err, busy, out_valid, out_ch, out_last, out_re, out_im
  );

endinterface

// File: rtl/dbf_mult_rs.sv
// One weight component: registered signed multiply (S1) then round/saturate (S2).
// Both stages advance only when en is high, so a downstream stall freezes them.
module dbf_mult_rs
  import dbf_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DBF_DW-1:0] a,
  input  logic signed [DBF_DW-1:0] b,
  output logic signed [DBF_DW-1:0] y
);

  logic signed [DBF_PW-1:0] prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      y    <= '0;
    end else if (en) begin
      prod <= DBF_PW'(a) * DBF_PW'(b);
      y    <= sat_shift(prod);
    end
  end

endmodule

// File: rtl/dbf_weight_seq.sv
// DBF weight generator: per-channel (amp, cos, sin) table streamed as A*(re + j*im).
// Rounding is selected by the DBF_ROUND_EN macro (default: truncation).
module dbf_weight_seq
  import dbf_pkg::*;
#(
  parameter int unsigned NUM_CH = DBF_NUM_CH
) (
  input  logic             clk,
  input  logic             rst,
  dbf_weight_seq_if.master bus
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CW   = CH_W + 1;

  state_t                   state;
  logic                     busy_q;
  logic                     wr_err_q;
  logic [CW-1:0]            rd_cnt;
  weight_t                  table_q [NUM_CH];

  logic                     stall;
  logic                     adv;
  logic                     issue;
  logic                     wr_ok;
  logic                     start_ok;
  logic                     last_hs;
  logic [CH_W-1:0]          rd_idx;

  logic                     s0_valid;
  logic                     s0_last;
  logic [CH_W-1:0]          s0_ch;
  weight_t                  s0_w;
  logic                     s1_valid;
  logic                     s1_last;
  logic [CH_W-1:0]          s1_ch;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic [CH_W-1:0]          out_ch_q;
  logic signed [DBF_DW-1:0] re_y;
  logic signed [DBF_DW-1:0] im_y;

  // Stall and handshake qualifiers shared by FSM, table and pipeline.
  always_comb begin
    stall    = out_valid_q && !bus.out_ready;
    adv      = !stall;
    issue    = (state == RUN) && (rd_cnt < CW'(NUM_CH));
    rd_idx   = issue ? rd_cnt[CH_W-1:0] : '0;
    wr_ok    = bus.wr_en && !busy_q && (CW'(bus.wr_addr) < CW'(NUM_CH));
    start_ok = bus.start && !busy_q;
    last_hs  = out_valid_q && bus.out_ready && out_last_q;
  end

  // Sweep control: one pass of the read counter per accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      rd_cnt   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_ok;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= RUN;
            busy_q <= 1'b1;
            rd_cnt <= '0;
          end
        end
        RUN: begin
          if (issue && adv) rd_cnt <= rd_cnt + CW'(1);
          if (last_hs) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weight table; a write in the start cycle lands before the first read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) table_q[i] <= '0;
    end else if (wr_ok) begin
      table_q[bus.wr_addr] <= '{amp: bus.wr_amp, re: bus.wr_re, im: bus.wr_im};
    end
  end

  // S0 read plus the side-band (valid/ch/last) that travels with S1 and S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid    <= 1'b0;
      s0_last     <= 1'b0;
      s0_ch       <= '0;
      s0_w        <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_ch       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else if (adv) begin
      s0_valid    <= issue;
      s0_last     <= issue && (rd_cnt == CW'(NUM_CH - 1));
      s0_ch       <= rd_idx;
      s0_w        <= table_q[rd_idx];
      s1_valid    <= s0_valid;
      s1_last     <= s0_last;
      s1_ch       <= s0_ch;
      out_valid_q <= s1_valid;
      out_last_q  <= s1_last;
      out_ch_q    <= s1_ch;
    end
  end

  dbf_mult_rs u_mul_re (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .a   (s0_w.amp),
    .b   (s0_w.re),
    .y   (re_y)
  );

  dbf_mult_rs u_mul_im (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .a   (s0_w.amp),
    .b   (s0_w.im),
    .y   (im_y)
  );

  assign bus.wr_err    = wr_err_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_re    = re_y;
  assign bus.out_im    = im_y;

endmodule

// File: tb/tb_dbf_weight_seq.sv
// Directed bench for dbf_weight_seq: hand-computed weight table swept under
// full-rate, random-backpressure, write-rejection and mid-sweep reset scenarios.
module tb_dbf_weight_seq;
  import dbf_pkg::*;

`ifdef DBF_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] amp, re, im, exp_re, exp_im;
  } vec_t;

  typedef struct packed {
    logic [3:0]  ch;
    logic        last;
    logic [15:0] re, im;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_tests = 0;
  int    n_fail  = 0;
  vec_t  vecs [16];
  beat_t beats [$];

  always #5 clk = ~clk;

  dbf_weight_seq_if #(.NUM_CH(16), .DW(16)) b ();
  dbf_weight_seq_if #(.NUM_CH(12), .DW(16)) b12 ();

  dbf_weight_seq #(.NUM_CH(16)) u_dut   (.clk(clk), .rst(rst), .bus(b.master));
  dbf_weight_seq #(.NUM_CH(12)) u_dut12 (.clk(clk), .rst(rst), .bus(b12.master));

  function automatic logic [15:0] pick(input logic [15:0] t, input logic [15:0] r);
    return ROUND ? r : t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},      64'(b.busy),      64'd0);
    check({tag, "_out_valid"}, 64'(b.out_valid), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check({tag, "_wr_err"},   64'(b.wr_err),   64'd0);
    check({tag, "_out_ch"},   64'(b.out_ch),   64'd0);
    check({tag, "_out_last"}, 64'(b.out_last), 64'd0);
    check({tag, "_out_re"},   64'(b.out_re),   64'd0);
    check({tag, "_out_im"},   64'(b.out_im),   64'd0);
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [15:0] amp, input logic [15:0] re,
                             input logic [15:0] im, input bit with_start);
    b.wr_en   = 1'b1;
    b.wr_addr = a;
    b.wr_amp  = amp;
    b.wr_re   = re;
    b.wr_im   = im;
    b.start   = with_start;
    @(negedge clk);
    b.wr_en = 1'b0;
    b.start = 1'b0;
    check($sformatf("wr_accept_ch%0d", a), 64'(b.wr_err), 64'd0);
  endtask

  task automatic pulse_start();
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
  endtask

  // Consume beats until out_last handshakes; checks stall stability and bubbles.
  task automatic collect(input bit rnd, input bit no_gap);
    int          cyc;
    bit          done;
    bit          stalled;
    bit          seen;
    logic [37:0] held;
    logic [37:0] cur;
    beats.delete();
    cyc = 0; done = 0; stalled = 0; seen = 0; held = '0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      cur = {b.out_valid, b.out_last, b.out_ch, b.out_re, b.out_im};
      if (stalled) check("stall_hold", 64'(cur), 64'(held));
      if (no_gap && seen) check("no_bubble", 64'(b.out_valid), 64'd1);
      b.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b.out_valid) seen = 1;
      stalled = b.out_valid && !b.out_ready;
      held = cur;
      if (b.out_valid && b.out_ready) begin
        beats.push_back('{b.out_ch, b.out_last, b.out_re, b.out_im});
        if (b.out_last) begin
          done = 1;
          check("busy_at_last", 64'(b.busy), 64'd1);
        end
      end
    end
    if (!done) check("sweep_timeout", 64'd0, 64'd1);
  endtask

  // mode 0: full table, 1: all zero, 2: only ch0 loaded
  task automatic compare_sweep(input int mode, input string tag);
    logic [15:0] er, ei;
    check({tag, "_beats"}, 64'(beats.size()), 64'd16);
    foreach (beats[i]) begin
      if (i < 16) begin
        if (mode == 0 || (mode == 2 && i == 0)) begin
          er = vecs[i].exp_re;
          ei = vecs[i].exp_im;
        end else begin
          er = '0;
          ei = '0;
        end
        check($sformatf("%s_ch%0d_idx", tag, i),  64'(beats[i].ch),   64'(i));
        check($sformatf("%s_ch%0d_last", tag, i), 64'(beats[i].last), 64'(i == 15));
        check($sformatf("%s_ch%0d_re", tag, i),   64'(beats[i].re),   64'(er));
        check($sformatf("%s_ch%0d_im", tag, i),   64'(beats[i].im),   64'(ei));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [37:0] snap;
    int          hs;
    int          cyc;

    vecs[0]  = '{16'h7FFF, 16'h2000, 16'h0000, pick(16'h1FFF, 16'h2000), 16'h0000};
    vecs[1]  = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8001};
    vecs[2]  = '{16'h4000, 16'h1000, 16'hF000, 16'h0800, 16'hF800};
    vecs[3]  = '{16'h4000, 16'h0001, 16'hFFFF, pick(16'h0000, 16'h0001), pick(16'hFFFF, 16'h0000)};
    vecs[4]  = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
    vecs[5]  = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFE, 16'h8001};
    vecs[6]  = '{16'h8000, 16'h4000, 16'hC000, 16'hC000, 16'h4000};
    vecs[7]  = '{16'h8000, 16'h8001, 16'h0001, 16'h7FFF, 16'hFFFF};
    vecs[8]  = '{16'h2000, 16'h4000, 16'h4000, 16'h1000, 16'h1000};
    vecs[9]  = '{16'hC000, 16'h2000, 16'hE000, 16'hF000, 16'h1000};
    vecs[10] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h8001, 16'h7FFF};
    vecs[11] = '{16'h4000, 16'h0003, 16'hFFFD, pick(16'h0001, 16'h0002), pick(16'hFFFE, 16'hFFFF)};
    vecs[12] = '{16'h7FFF, 16'h0001, 16'hFFFF, pick(16'h0000, 16'h0001), 16'hFFFF};
    vecs[13] = '{16'h1000, 16'h7FFF, 16'h8000, pick(16'h0FFF, 16'h1000), 16'hF000};
    vecs[14] = '{16'h0001, 16'h4000, 16'hC000, pick(16'h0000, 16'h0001), pick(16'hFFFF, 16'h0000)};
    vecs[15] = '{16'h6000, 16'h5000, 16'hB000, 16'h3C00, 16'hC400};

    b.wr_en = 0; b.wr_addr = '0; b.wr_amp = '0; b.wr_re = '0; b.wr_im = '0;
    b.start = 0; b.out_ready = 0;
    b12.wr_en = 0; b12.wr_addr = '0; b12.wr_amp = '0; b12.wr_re = '0; b12.wr_im = '0;
    b12.start = 0; b12.out_ready = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    // Out-of-range address on a 12-channel instance
    b12.wr_en = 1'b1; b12.wr_addr = 4'd12; b12.wr_amp = 16'h1111;
    @(negedge clk);
    check("wr_err_oob", 64'(b12.wr_err), 64'd1);
    b12.wr_addr = 4'd11;
    @(negedge clk);
    check("wr_err_last_ch", 64'(b12.wr_err), 64'd0);
    b12.wr_en = 1'b0;
    @(negedge clk);
    check("wr_err_idle", 64'(b12.wr_err), 64'd0);

    // Single entry: latency, stall hold, rounding of ch0
    write_entry(4'd0, vecs[0].amp, vecs[0].re, vecs[0].im, 1'b0);
    b.out_ready = 1'b0;
    pulse_start();
    check("lat_busy_rise", 64'(b.busy), 64'd1);
    check("lat_valid_e0", 64'(b.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid_e1", 64'(b.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid_e2", 64'(b.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid_e3", 64'(b.out_valid), 64'd1);
    check("lat_ch_e3", 64'(b.out_ch), 64'd0);
    check("lat_re_e3", 64'(b.out_re), 64'(vecs[0].exp_re));
    snap = {b.out_valid, b.out_last, b.out_ch, b.out_re, b.out_im};
    @(negedge clk);
    check("t1_stall_hold", 64'({b.out_valid, b.out_last, b.out_ch, b.out_re, b.out_im}), 64'(snap));
    collect(1'b0, 1'b1);
    compare_sweep(2, "t1");
    @(negedge clk);
    check_quiet("t1_end");

    // Full table; ch0 rewritten in the same cycle as start
    for (int i = 1; i < 16; i++) write_entry(4'(i), vecs[i].amp, vecs[i].re, vecs[i].im, 1'b0);
    write_entry(4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    write_entry(4'd0, vecs[0].amp, vecs[0].re, vecs[0].im, 1'b1);
    collect(1'b0, 1'b1);
    compare_sweep(0, "t3");
    @(negedge clk);
    check_quiet("t3_end");

    // Random backpressure
    pulse_start();
    collect(1'b1, 1'b0);
    compare_sweep(0, "t4");
    @(negedge clk);
    check_quiet("t4_end");

    // Write and start while busy are both rejected
    b.out_ready = 1'b1;
    pulse_start();
    b.wr_en = 1'b1; b.wr_addr = 4'd2; b.wr_amp = 16'h1234; b.wr_re = 16'h5678; b.wr_im = 16'h9ABC;
    b.start = 1'b1;
    @(negedge clk);
    b.wr_en = 1'b0; b.start = 1'b0;
    check("wr_err_busy", 64'(b.wr_err), 64'd1);
    @(negedge clk);
    check("wr_err_one_cycle", 64'(b.wr_err), 64'd0);
    collect(1'b0, 1'b1);
    compare_sweep(0, "t5");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t5_no_resweep_busy%0d", k), 64'(b.busy), 64'd0);
      check($sformatf("t5_no_resweep_valid%0d", k), 64'(b.out_valid), 64'd0);
    end

    // Reset after beat 5, then a clean sweep of the cleared table
    b.out_ready = 1'b1;
    pulse_start();
    hs = 0; cyc = 0;
    while (hs < 6 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (b.out_valid) hs++;
    end
    check("t6_beats_before_reset", 64'(hs), 64'd6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("t6_mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("t6_after_reset");
    pulse_start();
    collect(1'b0, 1'b1);
    compare_sweep(1, "t6");
    @(negedge clk);
    check_quiet("t6_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
